// File: rtl/collatz_pkg.sv
// collatz_pkg: shared FSM state type and default sizing for the Collatz sweep controller
package collatz_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, FIN} state_t;
  localparam int W_DEF = 8;
  localparam int TIMEOUT_DEF = 4096;
endpackage

// File: rtl/collatz_best_tracker.sv
// collatz_best_tracker: keeps the N with the largest step count, first-seen wins ties
module collatz_best_tracker import collatz_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         upd,
  input  logic         first,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] steps,
  output logic [W-1:0] best_n,
  output logic [W-1:0] best_steps
);
  // strict compare keeps the earlier (smaller) N on ties; first result always lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      best_n     <= '0;
      best_steps <= '0;
    end else if (clr) begin
      best_n     <= '0;
      best_steps <= '0;
    end else if (upd && (first || steps > best_steps)) begin
      best_n     <= cur;
      best_steps <= steps;
    end
endmodule

// File: rtl/collatz_sweep_ctrl.sv
// collatz_sweep_ctrl: sweeps N over [n_lo,n_hi] through an external Collatz core, tracking the argmax of steps
module collatz_sweep_ctrl import collatz_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] n_lo,
  input  logic [W-1:0] n_hi,
  output logic [W-1:0] core_n,
  output logic         core_go,
  input  logic         core_done,
  input  logic [W-1:0] core_steps,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] best_n,
  output logic [W-1:0] best_steps,
  output logic [W:0]   eval_cnt,
  output logic         err,
  output logic         tmo
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [W-1:0] cur, hi;
  logic [WW-1:0] wd;
  logic accept, bad_rng, hit, expired;
  assign accept  = state == IDLE && start;
  assign bad_rng = n_lo == '0 || n_lo > n_hi;
  assign hit     = state == WAIT && core_done;
  assign expired = state == WAIT && !core_done && wd == WW'(TIMEOUT - 1);
  assign core_n  = cur;
  assign core_go = state == LAUNCH;
  assign busy    = state != IDLE;
  assign done    = state == FIN;
  // next-state: NEXT tests cur against n_hi before any increment so the top value never wraps
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (bad_rng ? FIN : LAUNCH) : IDLE;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = (core_done || expired) ? NEXT : WAIT;
      NEXT:    nxt = cur == hi ? FIN : LAUNCH;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, range, watchdog and sweep counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      hi       <= '0;
      wd       <= '0;
      eval_cnt <= '0;
      err      <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      state <= nxt;
      wd    <= state == WAIT ? wd + 1'b1 : '0;
      if (accept) begin
        cur      <= n_lo;
        hi       <= n_hi;
        eval_cnt <= '0;
        err      <= bad_rng;
        tmo      <= 1'b0;
      end
      if (state == NEXT && cur != hi) cur <= cur + 1'b1;
      if (hit) eval_cnt <= eval_cnt + 1'b1;
      if (expired) tmo <= 1'b1;
    end
  collatz_best_tracker #(.W(W)) u_best (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .upd        (hit),
    .first      (eval_cnt == '0),
    .cur        (cur),
    .steps      (core_steps),
    .best_n     (best_n),
    .best_steps (best_steps)
  );
endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// tb_collatz_sweep_ctrl: random and directed sweeps against a behavioural Collatz core and result model
module tb_collatz_sweep_ctrl;
  localparam int W = 8;
  localparam int TMO = 4096;
  logic clk = 0, rst_n = 0, start = 0, core_done = 0;
  logic [W-1:0] n_lo = 0, n_hi = 0, core_steps = 0, core_n, best_n, best_steps;
  logic core_go, busy, done, err, tmo;
  logic [W:0] eval_cnt;
  int total = 0, bad = 0, done_cnt = 0, hang_n = -1;
  int exp_q[$];
  int exp_bn, exp_bs, exp_cnt, exp_err, exp_tmo;

  collatz_sweep_ctrl #(.TIMEOUT(TMO), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_lo(n_lo), .n_hi(n_hi),
    .core_n(core_n), .core_go(core_go), .core_done(core_done), .core_steps(core_steps),
    .busy(busy), .done(done), .best_n(best_n), .best_steps(best_steps),
    .eval_cnt(eval_cnt), .err(err), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int csteps(input int n);
    int s = 0;
    while (n != 1) begin
      n = (n % 2 == 0) ? n / 2 : 3 * n + 1;
      s++;
    end
    return s;
  endfunction

  // core model: result pulse a few cycles after the last step; hang_n never answers; stray pulses while idle
  initial begin
    int cd, st;
    bit pend;
    pend = 0; cd = 0; st = 0;
    forever begin
      @(negedge clk);
      core_done = 0;
      if (!rst_n) pend = 0;
      else begin
        if (pend) begin
          if (cd == 0) begin core_done = 1; core_steps = W'(st); pend = 0; end
          else cd--;
        end
        if (core_go) begin
          pend = int'(core_n) != hang_n;
          st = csteps(int'(core_n));
          cd = st + 2;
        end else if (!busy && !pend && $urandom_range(0, 5) == 0) begin
          core_done = 1;
          core_steps = W'($urandom);
        end
      end
    end
  end

  // compare process: launches follow the expected N order, core_n holds, results at done match the model
  initial begin
    bit launched;
    int last_n;
    launched = 0; last_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_zero_a", {core_n, core_go, busy, done, best_n, best_steps}, 0);
        chk("rst_zero_b", {eval_cnt, err, tmo}, 0);
        launched = 0;
      end else begin
        if (core_go) begin
          chk("go_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("core_n", core_n, exp_q.pop_front());
          last_n = int'(core_n);
          launched = 1;
        end else if (busy && launched) chk("core_n_hold", core_n, last_n);
        if (done) begin
          done_cnt++;
          chk("all_launched", exp_q.size(), 0);
          chk("best_n", best_n, exp_bn);
          chk("best_steps", best_steps, exp_bs);
          chk("eval_cnt", eval_cnt, exp_cnt);
          chk("err", err, exp_err);
          chk("tmo", tmo, exp_tmo);
          launched = 0;
        end
      end
    end
  end

  task automatic model(input int lo, input int hi);
    exp_q.delete();
    exp_bn = 0; exp_bs = 0; exp_cnt = 0; exp_tmo = 0;
    exp_err = (lo == 0 || lo > hi) ? 1 : 0;
    if (!exp_err)
      for (int n = lo; n <= hi; n++) begin
        exp_q.push_back(n);
        if (n == hang_n) exp_tmo = 1;
        else begin
          if (exp_cnt == 0 || csteps(n) > exp_bs) begin exp_bn = n; exp_bs = csteps(n); end
          exp_cnt++;
        end
      end
  endtask

  task automatic kick(input int lo, input int hi);
    @(negedge clk);
    n_lo = W'(lo); n_hi = W'(hi); start = 1;
    @(negedge clk);
    start = 0; n_lo = W'($urandom); n_hi = W'($urandom);
  endtask

  task automatic sweep(input int lo, input int hi);
    int d0, lim;
    model(lo, hi);
    d0 = done_cnt;
    kick(lo, hi);
    lim = exp_err ? 3 : (hi - lo + 1) * (TMO + 300);
    if (!exp_err) begin
      repeat (2) @(negedge clk);
      start = 1; n_lo = 8'd1; n_hi = 8'd2;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < lim && done_cnt == d0; i++) @(negedge clk);
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic lits(input int bn, input int bs, input int cnt, input int e, input int t);
    chk("lit_best_n", best_n, bn);
    chk("lit_best_steps", best_steps, bs);
    chk("lit_eval_cnt", eval_cnt, cnt);
    chk("lit_err", err, e);
    chk("lit_tmo", tmo, t);
    chk("lit_idle", busy, 0);
  endtask

  initial begin
    int d0, lo, hi;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    repeat (4) @(negedge clk);
    sweep(1, 10);   lits(9, 19, 10, 0, 0);
    sweep(27, 27);  lits(27, 111, 1, 0, 0);
    sweep(12, 13);  lits(12, 9, 2, 0, 0);
    sweep(5, 3);    lits(0, 0, 0, 1, 0);
    sweep(0, 9);    lits(0, 0, 0, 1, 0);
    sweep(250, 255); chk("lit_cnt_250", eval_cnt, 6);
    chk("lit_tmo_250", tmo, 0);
    hang_n = 252;
    sweep(250, 255); chk("lit_cnt_hang", eval_cnt, 5);
    chk("lit_tmo_hang", tmo, 1);
    hang_n = -1;
    model(1, 10);
    d0 = done_cnt;
    kick(1, 10);
    for (int i = 0; i < 2000 && exp_q.size() > 6; i++) @(negedge clk);
    chk("reached_4th", exp_q.size(), 6);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", done_cnt - d0, 0);
    sweep(1, 10);   lits(9, 19, 10, 0, 0);
    for (int k = 0; k < 14; k++) begin
      lo = $urandom_range(0, 255);
      hi = (k % 5 == 4) ? lo - 1 - $urandom_range(0, 3) : lo + $urandom_range(0, 5);
      if (hi > 255) hi = 255;
      if (hi < 0) hi = 0;
      hang_n = (k % 4 == 3) ? lo + $urandom_range(0, 2) : -1;
      sweep(lo, hi);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/collatz_sweep_ctrl.md
COLLATZ_SWEEP_CTRL -- requirements
Module: collatz_sweep_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, max cycles allowed per core evaluation.
REQ-002 SHALL have parameter W, default 8, width of N and step-count buses.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port n_lo  input  W  first N of sweep, sampled on accepted start.
REQ-007 SHALL have port n_hi  input  W  last N of sweep (inclusive), sampled on accepted start.
REQ-008 SHALL have port core_n  output  W  N presented to the Collatz core.
REQ-009 SHALL have port core_go  output  1  one-cycle launch pulse to the core.
REQ-010 SHALL have port core_done  input  1  one-cycle pulse, core finished; core_steps valid same cycle.
REQ-011 SHALL have port core_steps  input  W  step count from core (core saturates at 2^W-1).
REQ-012 SHALL have port busy  output  1  sweep in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-014 SHALL have port best_n, best_steps  output  W each  argmax of steps over the sweep, held until next accepted start.
REQ-015 SHALL have port eval_cnt  output  W+1  number of N values completed.
REQ-016 SHALL have port err  output  1  range invalid (n_lo==0 or n_lo>n_hi), held until next accepted start.
REQ-017 SHALL have port tmo  output  1  sticky, set if any evaluation timed out this sweep.

Function
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT, NEXT, FIN.
REQ-019 IDLE: start accepted only in IDLE; start in any other state SHALL be ignored.
REQ-020 On accepted start: latch range, clear best_n/best_steps/eval_cnt/err/tmo; if range invalid set err and go to FIN, else cur=n_lo, go LAUNCH.
REQ-021 LAUNCH: core_n=cur, core_go=1 for exactly one cycle, watchdog cleared, go WAIT.
REQ-022 core_n SHALL remain stable from LAUNCH until core_done or timeout.
REQ-023 WAIT: on core_done, if core_steps > best_steps (strict) or eval_cnt==0, update best_n=cur, best_steps=core_steps; eval_cnt+=1; go NEXT.
REQ-024 Ties SHALL keep the smaller N (first evaluated).
REQ-025 WAIT: if watchdog reaches TIMEOUT without core_done, set tmo, skip cur (no best update, eval_cnt unchanged), go NEXT.
REQ-026 core_done arriving outside WAIT SHALL be ignored.
REQ-027 NEXT: if cur==n_hi go FIN, else cur+=1 and go LAUNCH; comparison SHALL precede increment so n_hi=2^W-1 never wraps.
REQ-028 FIN: done=1 for one cycle, go IDLE.
REQ-029 busy SHALL be 1 in LAUNCH, WAIT, NEXT, FIN and 0 in IDLE.
REQ-030 Per-N overhead SHALL be 2 cycles (LAUNCH, NEXT) plus core latency.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE and all outputs to 0 (core_n, core_go, busy, done, best_n, best_steps, eval_cnt, err, tmo).
REQ-032 Reset mid-sweep SHALL abandon the sweep with no done pulse; first start after release SHALL be accepted normally.

Structure
REQ-033 Shared package collatz_pkg SHALL hold the FSM state enum, W default, TIMEOUT default.
REQ-034 Sub-module collatz_best_tracker SHALL hold best_n/best_steps compare-and-update logic; watchdog and FSM stay in top.

Verification (bench uses a behavioural Collatz core model, core_done 3 cycles after final step)
REQ-035 n_lo=1, n_hi=10, start -> done once; best_n=9, best_steps=19, eval_cnt=10, err=0, tmo=0.
REQ-036 n_lo=n_hi=27 -> best_n=27, best_steps=111, eval_cnt=1.
REQ-037 n_lo=12, n_hi=13 (both 9 steps) -> best_n=12, best_steps=9.
REQ-038 n_lo=5, n_hi=3 and separately n_lo=0 -> err=1, eval_cnt=0, done within 3 cycles, no core_go.
REQ-039 n_lo=250, n_hi=255 -> eval_cnt=6, done once, cur never wraps to 0; core model that never asserts done for N=252 -> tmo=1, eval_cnt=5.
REQ-040 rst_n low during WAIT of sweep 1..10, then new start 1..10 -> outputs 0 during reset, no done, second sweep matches REQ-035; start pulsed while busy ignored.
